// File: rtl/writeback_arbiter_if.sv
// writeback_arbiter_if: ALU/load/issue inputs, scoreboard queries and register-file write port
interface writeback_arbiter_if;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        load_valid;
  logic        load_ready;
  logic [4:0]  load_rd;
  logic [31:0] load_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  query_rs1;
  logic [4:0]  query_rs2;
  logic [4:0]  query_rd;
  logic        busy_rs1;
  logic        busy_rs2;
  logic        busy_rd;
  logic        write_enable;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  modport slave (
    input  alu_valid, alu_rd, alu_data, load_valid, load_rd, load_data,
           issue_valid, issue_rd, query_rs1, query_rs2, query_rd,
    output load_ready, busy_rs1, busy_rs2, busy_rd, write_enable, write_addr, write_data
  );
  modport master (
    output alu_valid, alu_rd, alu_data, load_valid, load_rd, load_data,
           issue_valid, issue_rd, query_rs1, query_rs2, query_rd,
    input  load_ready, busy_rs1, busy_rs2, busy_rd, write_enable, write_addr, write_data
  );
endinterface

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: ALU-priority merge of ALU and FIFO-buffered load results onto one register-file write port, with pending-load scoreboard; WB_LOAD_BYPASS_EN lets a load skip the empty FIFO
module writeback_arbiter #(
  parameter int DEPTH = 4
) (
  input logic clock,
  input logic async_reset,
  writeback_arbiter_if.slave wb
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [4:0]    fifo_rd   [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [31:0]   pending, pending_next, set_mask, clr_mask;
  logic          push, pop, bypass, fifo_push, sel_valid;
  logic [4:0]    sel_rd;
  logic [31:0]   sel_data;
  logic          we_q;
  logic [4:0]    addr_q;
  logic [31:0]   data_q;
  assign wb.load_ready   = count != FULL;
  assign push            = wb.load_valid && wb.load_ready;
  assign pop             = !wb.alu_valid && count != '0;
`ifdef WB_LOAD_BYPASS_EN
  assign bypass          = !wb.alu_valid && count == '0 && push;
`else
  assign bypass          = 1'b0;
`endif
  assign fifo_push       = push && !bypass;
  assign wb.busy_rs1     = pending[wb.query_rs1];
  assign wb.busy_rs2     = pending[wb.query_rs2];
  assign wb.busy_rd      = pending[wb.query_rd];
  assign wb.write_enable = we_q;
  assign wb.write_addr   = addr_q;
  assign wb.write_data   = data_q;
  // Pick the winning result (ALU > FIFO head > bypassed load) and the scoreboard update; a same-cycle set overrides the clear
  always_comb begin
    sel_valid    = wb.alu_valid || pop || bypass;
    sel_rd       = wb.alu_valid ? wb.alu_rd : pop ? fifo_rd[rd_ptr] : wb.load_rd;
    sel_data     = wb.alu_valid ? wb.alu_data : pop ? fifo_data[rd_ptr] : wb.load_data;
    clr_mask     = (pop || bypass) ? (32'd1 << sel_rd) : 32'd0;
    set_mask     = wb.issue_valid ? (32'd1 << wb.issue_rd) : 32'd0;
    pending_next = ((pending & ~clr_mask) | set_mask) & ~32'd1;
  end
  // Load FIFO storage; contents need no reset because count gates every read
  always_ff @(posedge clock) begin
    if (fifo_push) begin
      fifo_rd[wr_ptr]   <= wb.load_rd;
      fifo_data[wr_ptr] <= wb.load_data;
    end
  end
  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clock or posedge async_reset) begin
    if (async_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(fifo_push);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + (AW+1)'(fifo_push) - (AW+1)'(pop);
    end
  end
  // Pending-load scoreboard
  always_ff @(posedge clock or posedge async_reset) begin
    if (async_reset) pending <= '0;
    else pending <= pending_next;
  end
  // Registered write port; x0 results are consumed but never strobe, idle cycles hold address and data
  always_ff @(posedge clock or posedge async_reset) begin
    if (async_reset) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else if (sel_valid) begin
      we_q   <= sel_rd != 5'd0;
      addr_q <= sel_rd;
      data_q <= sel_data;
    end else begin
      we_q   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: table vectors, corner-case sequences and random traffic against a queue-based reference model
module tb_writeback_arbiter;
  localparam int DEPTH = 4;
  logic clock = 1'b0;
  logic async_reset = 1'b1;
  int passed = 0;
  int total = 0;
  writeback_arbiter_if wb();
  writeback_arbiter #(.DEPTH(DEPTH)) dut (.clock(clock), .async_reset(async_reset), .wb(wb));
  always #5 clock = ~clock;
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;
  typedef struct {
    bit          av;
    logic [4:0]  ar;
    logic [31:0] ad;
    bit          exp_we;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
  } vec_t;
  ent_t        mq[$];
  bit          mpend[32];
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [4:0]  wlog[$];
  bit          last_acc;
  vec_t        tbl[6];
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic model_reset();
    mq.delete();
    foreach (mpend[i]) mpend[i] = 1'b0;
    m_we = 1'b0;
    m_addr = '0;
    m_data = '0;
  endtask
  task automatic drive(bit av, logic [4:0] ar, logic [31:0] ad, bit lv, logic [4:0] lr,
                       logic [31:0] ld, bit iv, logic [4:0] ir);
    wb.alu_valid = av;
    wb.alu_rd = ar;
    wb.alu_data = ad;
    wb.load_valid = lv;
    wb.load_rd = lr;
    wb.load_data = ld;
    wb.issue_valid = iv;
    wb.issue_rd = ir;
  endtask
  task automatic query(logic [4:0] a, logic [4:0] b, logic [4:0] c);
    wb.query_rs1 = a;
    wb.query_rs2 = b;
    wb.query_rd = c;
  endtask
  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  // One clock: check pre-edge combinational outputs, advance the model, check the write port
  task automatic cyc();
    bit av, lv, iv, acc, byp;
    logic [4:0] ar, lr, ir;
    logic [31:0] ad, ld;
    ent_t h;
    #1;
    chk("load_ready", wb.load_ready, mq.size() < DEPTH);
    chk("busy_rs1", wb.busy_rs1, mpend[wb.query_rs1]);
    chk("busy_rs2", wb.busy_rs2, mpend[wb.query_rs2]);
    chk("busy_rd", wb.busy_rd, mpend[wb.query_rd]);
    av = wb.alu_valid; ar = wb.alu_rd; ad = wb.alu_data;
    lv = wb.load_valid; lr = wb.load_rd; ld = wb.load_data;
    iv = wb.issue_valid; ir = wb.issue_rd;
    acc = lv && mq.size() < DEPTH;
    byp = 1'b0;
    @(posedge clock);
    if (av) begin
      m_we = ar != 0; m_addr = ar; m_data = ad;
    end else if (mq.size() > 0) begin
      h = mq.pop_front();
      m_we = h.rd != 0; m_addr = h.rd; m_data = h.data;
      mpend[h.rd] = 1'b0;
    end
`ifdef WB_LOAD_BYPASS_EN
    else if (acc) begin
      byp = 1'b1;
      m_we = lr != 0; m_addr = lr; m_data = ld;
      mpend[lr] = 1'b0;
    end
`endif
    else m_we = 1'b0;
    if (acc && !byp) begin
      h.rd = lr; h.data = ld;
      mq.push_back(h);
    end
    if (iv && ir != 0) mpend[ir] = 1'b1;
    mpend[0] = 1'b0;
    last_acc = acc;
    #1;
    chk("write_enable", wb.write_enable, m_we);
    if (m_we) begin
      chk("write_addr", wb.write_addr, m_addr);
      chk("write_data", wb.write_data, m_data);
    end
    if (wb.write_enable) wlog.push_back(wb.write_addr);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    int n;
    idle();
    query(0, 0, 0);
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_we", wb.write_enable, 0);
    chk("rst_addr", wb.write_addr, 0);
    chk("rst_data", wb.write_data, 0);
    chk("rst_ready", wb.load_ready, 1);
    async_reset = 1'b0;
    tbl[0] = '{1, 5'd4, 32'hABCDE123, 1, 5'd4, 32'hABCDE123};
    tbl[1] = '{0, 5'd0, 32'h0, 0, 5'd0, 32'h0};
    tbl[2] = '{1, 5'd0, 32'h11111111, 0, 5'd0, 32'h0};
    tbl[3] = '{1, 5'd31, 32'hFFFFFFFF, 1, 5'd31, 32'hFFFFFFFF};
    tbl[4] = '{1, 5'd1, 32'h00000000, 1, 5'd1, 32'h00000000};
    tbl[5] = '{0, 5'd9, 32'h12345678, 0, 5'd0, 32'h0};
    foreach (tbl[i]) begin
      drive(tbl[i].av, tbl[i].ar, tbl[i].ad, 0, 0, 0, 0, 0);
      cyc();
      chk("tbl_we", wb.write_enable, tbl[i].exp_we);
      if (tbl[i].exp_we) begin
        chk("tbl_addr", wb.write_addr, tbl[i].exp_addr);
        chk("tbl_data", wb.write_data, tbl[i].exp_data);
      end
    end
    query(0, 0, 25);
    drive(0, 0, 0, 0, 0, 0, 1, 25);
    cyc();
    drive(1, 2, 32'h22, 1, 25, 32'h98765432, 0, 0);
    cyc();
    chk("ld_vs_alu_busy0", wb.busy_rd, 1);
    drive(1, 2, 32'h23, 0, 0, 0, 0, 0);
    cyc();
    chk("ld_vs_alu_busy1", wb.busy_rd, 1);
    drive(1, 2, 32'h24, 0, 0, 0, 0, 0);
    cyc();
    chk("ld_vs_alu_busy2", wb.busy_rd, 1);
    idle();
    cyc();
    chk("ld_vs_alu_we", wb.write_enable, 1);
    chk("ld_vs_alu_addr", wb.write_addr, 25);
    chk("ld_vs_alu_data", wb.write_data, 32'h98765432);
    chk("ld_vs_alu_busy_clr", wb.busy_rd, 0);
    cyc();
    wlog.delete();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 1, 5'(i + 1), 32'h1000 + i, 0, 0);
      cyc();
    end
    chk("full_ready", wb.load_ready, 0);
    drive(1, 0, 0, 1, 20, 32'hDEAD, 0, 0);
    cyc();
    for (int k = 0; k < 8; k++) begin
      drive(0, 0, 0, 1, 5'(k + 5), 32'h2000 + k, 0, 0);
      n = 0;
      do begin
        cyc();
        n++;
      end while (!last_acc && n < 10);
      chk("wrap_push_accepted", last_acc, 1);
    end
    idle();
    n = 0;
    while (wlog.size() < 12 && n < 20) begin
      cyc();
      n++;
    end
    chk("wrap_count", wlog.size(), 12);
    for (int i = 0; i < 12 && i < wlog.size(); i++) chk("wrap_order", wlog[i], i + 1);
    query(0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    cyc();
    chk("busy_x0", wb.busy_rd, 0);
    drive(0, 0, 0, 1, 0, 32'h55, 0, 0);
    cyc();
    idle();
    cyc();
    cyc();
    query(7, 0, 7);
    drive(1, 0, 0, 0, 0, 0, 1, 7);
    cyc();
    drive(1, 0, 0, 1, 7, 32'h77, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 1, 7);
    cyc();
    chk("pop7_we", wb.write_enable, 1);
    chk("pop7_addr", wb.write_addr, 7);
    chk("set_wins_busy", wb.busy_rd, 1);
    idle();
    cyc();
    chk("set_wins_hold", wb.busy_rs1, 1);
    query(10, 11, 12);
    for (int i = 0; i < 3; i++) begin
      drive(1, 3, 32'h333, 1, 5'(10 + i), 32'h3000 + i, 1, 5'(10 + i));
      cyc();
    end
    #2;
    async_reset = 1'b1;
    #1;
    chk("mid_rst_we", wb.write_enable, 0);
    chk("mid_rst_addr", wb.write_addr, 0);
    chk("mid_rst_data", wb.write_data, 0);
    chk("mid_rst_ready", wb.load_ready, 1);
    chk("mid_rst_busy_rs1", wb.busy_rs1, 0);
    chk("mid_rst_busy_rs2", wb.busy_rs2, 0);
    chk("mid_rst_busy_rd", wb.busy_rd, 0);
    model_reset();
    idle();
    @(posedge clock);
    #1;
    chk("rst_hold_we", wb.write_enable, 0);
    async_reset = 1'b0;
    wlog.delete();
    repeat (5) cyc();
    chk("no_stale_writes", wlog.size(), 0);
    drive(0, 0, 0, 1, 9, 32'h1, 0, 0);
    cyc();
    idle();
`ifdef WB_LOAD_BYPASS_EN
    chk("byp_we_k1", wb.write_enable, 1);
    chk("byp_addr_k1", wb.write_addr, 9);
    cyc();
    chk("byp_we_k2", wb.write_enable, 0);
`else
    chk("nobyp_we_k1", wb.write_enable, 0);
    cyc();
    chk("nobyp_we_k2", wb.write_enable, 1);
    chk("nobyp_addr_k2", wb.write_addr, 9);
`endif
    for (int i = 0; i < 400; i++) begin
      query(5'($urandom), 5'($urandom), 5'($urandom));
      drive($urandom_range(0, 2) == 0, 5'($urandom), $urandom, $urandom_range(0, 1) == 1,
            5'($urandom), $urandom, $urandom_range(0, 3) == 0, 5'($urandom));
      cyc();
    end
    idle();
    repeat (8) cyc();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
